// File: rtl/if_id_issue_ctrl.sv
// Dual-issue front-end controller: sequences the IF/ID register, steers the held pair onto even/odd pipes,
// splits incompatible or dependent pairs over two cycles, owns flush bubbles and saturating issue counters.
module if_id_issue_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic             first_pipe,
    input  logic             second_pipe,
    input  logic             raw_dep,
    input  logic             ext_stall,
    input  logic             flush,
    output logic             if_id_en,
    output logic             if_id_clr,
    output logic             pc_hold,
    output logic             even_valid,
    output logic             even_sel,
    output logic             odd_valid,
    output logic             odd_sel,
    output logic [CNT_W-1:0] cnt_dual,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_stall
);

    typedef enum logic [1:0] {IDLE, PAIR, SECOND, FLUSH} state_t;

    localparam logic [3:0]       FCNT_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] fcnt;
    logic [3:0] fcnt_nxt;
    logic       dual_ok;
    logic       inc_dual;
    logic       inc_single;
    logic       inc_stall;

    assign dual_ok = (first_pipe != second_pipe) && !raw_dep;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        if (flush) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FCNT_INIT;
        end else begin
            case (state)
                IDLE: state_nxt = fetch_valid ? PAIR : IDLE;
                PAIR: begin
                    if (!ext_stall) begin
                        if (dual_ok) state_nxt = fetch_valid ? PAIR : IDLE;
                        else         state_nxt = SECOND;
                    end
                end
                SECOND: begin
                    if (!ext_stall) state_nxt = fetch_valid ? PAIR : IDLE;
                end
                FLUSH: begin
                    if (fcnt != 4'd0) fcnt_nxt  = fcnt - 4'd1;
                    else              state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Issue only happens on the normal-issue branch, so if_id_clr and a valid can never coincide.
    always_comb begin
        if_id_en   = 1'b0;
        if_id_clr  = 1'b0;
        pc_hold    = 1'b0;
        even_valid = 1'b0;
        even_sel   = 1'b0;
        odd_valid  = 1'b0;
        odd_sel    = 1'b0;
        inc_dual   = 1'b0;
        inc_single = 1'b0;
        inc_stall  = 1'b0;
        if (rst) begin
            if_id_clr = 1'b1;
            pc_hold   = 1'b1;
        end else if (flush) begin
            if_id_clr = 1'b1;
        end else begin
            case (state)
                IDLE: if_id_en = 1'b1;
                PAIR: begin
                    if (ext_stall) begin
                        pc_hold   = 1'b1;
                        inc_stall = 1'b1;
                    end else if (dual_ok) begin
                        if_id_en   = 1'b1;
                        even_valid = 1'b1;
                        odd_valid  = 1'b1;
                        even_sel   = first_pipe;
                        odd_sel    = ~first_pipe;
                        inc_dual   = 1'b1;
                    end else begin
                        pc_hold    = 1'b1;
                        inc_single = 1'b1;
                        if (first_pipe) odd_valid  = 1'b1;
                        else            even_valid = 1'b1;
                    end
                end
                SECOND: begin
                    if (ext_stall) begin
                        pc_hold   = 1'b1;
                        inc_stall = 1'b1;
                    end else begin
                        if_id_en   = 1'b1;
                        inc_single = 1'b1;
                        if (second_pipe) begin
                            odd_valid = 1'b1;
                            odd_sel   = 1'b1;
                        end else begin
                            even_valid = 1'b1;
                            even_sel   = 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if_id_clr = 1'b1;
                    pc_hold   = 1'b1;
                end
                default: if_id_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_dual   <= '0;
            cnt_single <= '0;
            cnt_stall  <= '0;
        end else begin
            if (inc_dual   && cnt_dual   != CNT_MAX) cnt_dual   <= cnt_dual   + 1'b1;
            if (inc_single && cnt_single != CNT_MAX) cnt_single <= cnt_single + 1'b1;
            if (inc_stall  && cnt_stall  != CNT_MAX) cnt_stall  <= cnt_stall  + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_issue_ctrl.sv
// Bench for if_id_issue_ctrl: directed vector table, hand sequences for saturation/reset, random vs. model.
module tb_if_id_issue_ctrl;

    localparam int FC   = 2;
    localparam int CW_A = 16;
    localparam int CW_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, fv, fp, sp, raw, stall, flush;
    logic a_en, a_clr, a_hold, a_ev, a_es, a_ov, a_os;
    logic b_en, b_clr, b_hold, b_ev, b_es, b_ov, b_os;
    logic [CW_A-1:0] a_cd, a_cs, a_ct;
    logic [CW_B-1:0] b_cd, b_cs, b_ct;

    if_id_issue_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .fetch_valid(fv), .first_pipe(fp), .second_pipe(sp), .raw_dep(raw),
        .ext_stall(stall), .flush(flush), .if_id_en(a_en), .if_id_clr(a_clr), .pc_hold(a_hold),
        .even_valid(a_ev), .even_sel(a_es), .odd_valid(a_ov), .odd_sel(a_os),
        .cnt_dual(a_cd), .cnt_single(a_cs), .cnt_stall(a_ct));

    if_id_issue_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .fetch_valid(fv), .first_pipe(fp), .second_pipe(sp), .raw_dep(raw),
        .ext_stall(stall), .flush(flush), .if_id_en(b_en), .if_id_clr(b_clr), .pc_hold(b_hold),
        .even_valid(b_ev), .even_sel(b_es), .odd_valid(b_ov), .odd_sel(b_os),
        .cnt_dual(b_cd), .cnt_single(b_cs), .cnt_stall(b_ct));

    typedef struct {
        logic       r, f_v, f_p, s_p, rw, st, fl;
        logic [6:0] exp;   // {if_id_en, if_id_clr, pc_hold, even_valid, even_sel, odd_valid, odd_sel}
        int         d, s, t;
    } vec_t;

    vec_t tbl[22];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: pending = instructions still held (0, 2 = whole pair, 1 = second only)
    int m_pend = 0;
    int m_bub  = 0;
    int m_d    = 0;
    int m_s    = 0;
    int m_t    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, f_v, f_p, s_p, rw, st, fl,
                                input logic [6:0] e, input int d, s, t);
        vec_t v;
        v.r = r; v.f_v = f_v; v.f_p = f_p; v.s_p = s_p; v.rw = rw; v.st = st; v.fl = fl;
        v.exp = e; v.d = d; v.s = s; v.t = t;
        return v;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [6:0] outs_a();
        return {a_en, a_clr, a_hold, a_ev, a_es, a_ov, a_os};
    endfunction

    function automatic logic [6:0] outs_b();
        return {b_en, b_clr, b_hold, b_ev, b_es, b_ov, b_os};
    endfunction

    task automatic model_step(output logic [6:0] e);
        logic en, clr, hold, ev, es, ov, os;
        en = 0; clr = 0; hold = 0; ev = 0; es = 0; ov = 0; os = 0;
        if (rst) begin
            clr = 1; hold = 1;
            m_pend = 0; m_bub = 0; m_d = 0; m_s = 0; m_t = 0;
        end else if (flush) begin
            clr = 1; m_pend = 0; m_bub = FC;
        end else if (m_bub > 0) begin
            clr = 1; hold = 1; m_bub--;
        end else if (m_pend == 0) begin
            en = 1; m_pend = fv ? 2 : 0;
        end else if (stall) begin
            hold = 1; m_t++;
        end else if (m_pend == 2 && fp != sp && !raw) begin
            if (fp == 1'b0) begin ev = 1; es = 0; ov = 1; os = 1; end
            else            begin ov = 1; os = 0; ev = 1; es = 1; end
            en = 1; m_d++; m_pend = fv ? 2 : 0;
        end else if (m_pend == 2) begin
            if (fp == 1'b0) ev = 1; else ov = 1;
            hold = 1; m_s++; m_pend = 1;
        end else begin
            if (sp == 1'b0) begin ev = 1; es = 1; end else begin ov = 1; os = 1; end
            en = 1; m_s++; m_pend = fv ? 2 : 0;
        end
        e = {en, clr, hold, ev, es, ov, os};
    endtask

    int          seq6[5] = '{1, 2, 3, 3, 3};
    logic [6:0]  e;

    initial begin
        tbl[0]  = mk(1,0,0,0,0,0,0, 7'b0110000, 0,0,0);
        tbl[1]  = mk(1,0,0,0,0,0,0, 7'b0110000, 0,0,0);
        tbl[2]  = mk(0,1,0,1,0,0,0, 7'b1000000, 0,0,0);
        tbl[3]  = mk(0,0,0,1,0,0,0, 7'b1001011, 0,0,0);
        tbl[4]  = mk(0,1,1,1,0,0,0, 7'b1000000, 1,0,0);
        tbl[5]  = mk(0,0,1,1,0,0,0, 7'b0010010, 1,0,0);
        tbl[6]  = mk(0,0,1,1,0,0,0, 7'b1000011, 1,1,0);
        tbl[7]  = mk(0,1,0,1,1,0,0, 7'b1000000, 1,2,0);
        tbl[8]  = mk(0,0,0,1,1,0,0, 7'b0011000, 1,2,0);
        tbl[9]  = mk(0,0,0,1,1,0,0, 7'b1000011, 1,3,0);
        tbl[10] = mk(0,1,0,0,0,0,0, 7'b1000000, 1,4,0);
        tbl[11] = mk(0,0,0,0,0,0,0, 7'b0011000, 1,4,0);
        tbl[12] = mk(0,0,0,0,0,1,0, 7'b0010000, 1,5,0);
        tbl[13] = mk(0,0,0,0,0,1,0, 7'b0010000, 1,5,1);
        tbl[14] = mk(0,0,0,0,0,1,0, 7'b0010000, 1,5,2);
        tbl[15] = mk(0,0,0,0,0,0,0, 7'b1001100, 1,5,3);
        tbl[16] = mk(0,1,1,0,1,0,0, 7'b1000000, 1,6,3);
        tbl[17] = mk(0,0,1,0,1,0,0, 7'b0010010, 1,6,3);
        tbl[18] = mk(0,0,1,0,1,0,1, 7'b0100000, 1,7,3);
        tbl[19] = mk(0,1,0,0,0,0,0, 7'b0110000, 1,7,3);
        tbl[20] = mk(0,1,0,0,0,0,0, 7'b0110000, 1,7,3);
        tbl[21] = mk(0,0,0,0,0,0,0, 7'b1000000, 1,7,3);

        for (int i = 0; i < 22; i++) begin
            rst = tbl[i].r; fv = tbl[i].f_v; fp = tbl[i].f_p; sp = tbl[i].s_p;
            raw = tbl[i].rw; stall = tbl[i].st; flush = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("vec%0d_outs_a", i), 32'(outs_a()), 32'(tbl[i].exp));
            chk($sformatf("vec%0d_outs_b", i), 32'(outs_b()), 32'(tbl[i].exp));
            chk($sformatf("vec%0d_cnt_dual", i),   32'(a_cd), 32'(tbl[i].d));
            chk($sformatf("vec%0d_cnt_single", i), 32'(a_cs), 32'(tbl[i].s));
            chk($sformatf("vec%0d_cnt_stall", i),  32'(a_ct), 32'(tbl[i].t));
            chk($sformatf("vec%0d_b_cnt_single", i), 32'(b_cs), 32'(sat(tbl[i].s, CW_B)));
            @(posedge clk); #1;
        end

        // Back-to-back dual pairs on the 2-bit-counter instance, then reset mid-stream
        rst = 1; fv = 0; fp = 0; sp = 1; raw = 0; stall = 0; flush = 0;
        @(posedge clk); #1;
        rst = 0; fv = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("sat_dual_issue%0d", k), 32'({b_ev, b_es, b_ov, b_os}), 32'(4'b1011));
            @(posedge clk); #1;
            chk($sformatf("sat_cnt_dual%0d", k), 32'(b_cd), 32'(seq6[k]));
        end
        chk("pre_rst_cnt_dual_a", 32'(a_cd), 32'd5);
        rst = 1;
        #1;
        chk("mid_rst_outs", 32'(outs_a()), 32'(7'b0110000));
        @(posedge clk); #1;
        chk("mid_rst_cnts_a", 32'({a_cd, a_cs, a_ct}), 32'd0);
        chk("mid_rst_cnts_b", 32'({b_cd, b_cs, b_ct}), 32'd0);
        rst = 0; fv = 0;
        #1;
        chk("post_rst_idle_a", 32'(outs_a()), 32'(7'b1000000));
        chk("post_rst_idle_b", 32'(outs_b()), 32'(7'b1000000));
        @(posedge clk); #1;

        // Randomised run against the pending-slot model
        for (int i = 0; i < 4000; i++) begin
            rst   = (i == 0) || ($urandom_range(63) == 0);
            flush = ($urandom_range(15) == 0);
            stall = flush ? 1'b0 : ($urandom_range(3) == 0);
            fv    = ($urandom_range(3) != 0);
            fp    = 1'($urandom_range(1));
            sp    = 1'($urandom_range(1));
            raw   = ($urandom_range(3) == 0);
            @(negedge clk);
            if (i > 0) begin
                chk("rnd_cnt_dual_a",   32'(a_cd), 32'(sat(m_d, CW_A)));
                chk("rnd_cnt_single_a", 32'(a_cs), 32'(sat(m_s, CW_A)));
                chk("rnd_cnt_stall_a",  32'(a_ct), 32'(sat(m_t, CW_A)));
                chk("rnd_cnts_b", 32'({b_cd, b_cs, b_ct}),
                    32'({2'(sat(m_d, CW_B)), 2'(sat(m_s, CW_B)), 2'(sat(m_t, CW_B))}));
            end
            model_step(e);
            chk("rnd_outs_a", 32'(outs_a()), 32'(e));
            chk("rnd_outs_b", 32'(outs_b()), 32'(e));
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
